acs_scheduler: RTL and testbench

//  Path-metric unit controller for the K=3, rate-1/2 Viterbi decoder. Per received

---
 rtl/viterbi_pkg.sv | 37 +++
 rtl/acs_scheduler_acs.sv | 35 +++
 rtl/acs_scheduler.sv | 151 +++++++++++++++
 tb/tb_acs_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=3, rate-1/2 Viterbi path-metric unit.
// Contents: metric/branch-metric widths, INF saturation value, metric bank
// type, reset metric pattern, scheduler FSM states, code-word helper.
package viterbi_pkg;

    localparam int unsigned METRIC_W   = 4;
    localparam int unsigned BM_W       = 2;
    localparam int unsigned NUM_STATES = 4;
    localparam int unsigned STATE_W    = 2;
    localparam int unsigned GEN_W      = 3;

    localparam logic [METRIC_W-1:0] INF = 4'hF;

    typedef logic [METRIC_W-1:0]                  metric_t;
    typedef logic [NUM_STATES-1:0][METRIC_W-1:0]  metric_bank_t;
    // Branch metrics indexed by code word {c0,c1}
    typedef logic [NUM_STATES-1:0][BM_W-1:0]      bm_vec_t;

    // State 0 is the known start state, all others unreachable
    localparam metric_bank_t RESET_METRICS = {INF, INF, INF, metric_t'(0)};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    // Code word {c0,c1} emitted for encoder register contents {u, p}
    function automatic logic [BM_W-1:0] branch_cw(
        input logic [GEN_W-1:0] g0,
        input logic [GEN_W-1:0] g1,
        input logic [GEN_W-1:0] enc_reg
    );
        return {^(g0 & enc_reg), ^(g1 & enc_reg)};
    endfunction

endpackage

// File: rtl/acs_scheduler_acs.sv
// Add-compare-select unit: one trellis state per evaluation.
// Ports: pm0/pm1 predecessor metrics, bm0/bm1 branch metrics,
//        cost_c surviving path cost, decision_c (1 = branch 1 won).
// INF on a predecessor propagates; sums above INF saturate; ties pick branch 0.
module acs
    import viterbi_pkg::*;
(
    input  logic [METRIC_W-1:0] pm0,
    input  logic [METRIC_W-1:0] pm1,
    input  logic [BM_W-1:0]     bm0,
    input  logic [BM_W-1:0]     bm1,
    output logic [METRIC_W-1:0] cost_c,
    output logic                decision_c
);

    function automatic metric_t add_sat(input metric_t pm, input logic [BM_W-1:0] bm);
        logic [METRIC_W:0] sum;
        sum = {1'b0, pm} + (METRIC_W+1)'(bm);
        if (pm == INF || sum > {1'b0, INF}) begin
            return INF;
        end
        return sum[METRIC_W-1:0];
    endfunction

    metric_t cand0;
    metric_t cand1;

    always_comb begin
        cand0      = add_sat(pm0, bm0);
        cand1      = add_sat(pm1, bm1);
        decision_c = (cand1 < cand0);
        cost_c     = decision_c ? cand1 : cand0;
    end

endmodule

// File: rtl/acs_scheduler.sv
// Path-metric controller for the K=3 rate-1/2 Viterbi decoder. Accepts four
// branch metrics per symbol, runs one shared ACS over the 4 states (one per
// cycle), keeps metrics in ping-pong banks and presents a decision vector.
// Ports: clk, rst_n (async active-low), frame_start (metric reinit),
//        bm_valid/bm_ready/bm_in (branch metrics in),
//        dec_valid/dec_ready/dec_vec (decisions out),
//        best_state/best_metric (argmin/min of new metrics), busy.
// Build option: METRIC_NORM_EN enables metric normalization on hand-off.
module acs_scheduler
    import viterbi_pkg::*;
#(
    parameter logic [GEN_W-1:0]    G0          = 3'b111,
    parameter logic [GEN_W-1:0]    G1          = 3'b101,
    parameter logic [METRIC_W-1:0] NORM_THRESH = 4'd8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  bm_valid,
    output logic                  bm_ready,
    input  logic [7:0]            bm_in,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output logic [NUM_STATES-1:0] dec_vec,
    output logic [STATE_W-1:0]    best_state,
    output logic [METRIC_W-1:0]   best_metric,
    output logic                  busy
);

`ifdef METRIC_NORM_EN
    localparam bit NORM_EN = 1'b1;
`else
    localparam bit NORM_EN = 1'b0;
`endif

    fsm_state_t          state;
    fsm_state_t          state_next;
    logic [STATE_W-1:0]  cnt;
    bm_vec_t             bm_reg;
    metric_bank_t [1:0]  bank;
    logic                sel;

    logic                wr_bank_c;
    logic [STATE_W-1:0]  p0_c;
    logic [STATE_W-1:0]  p1_c;
    logic [BM_W-1:0]     bm0_c;
    logic [BM_W-1:0]     bm1_c;
    metric_t             cost_c;
    logic                decision_c;
    logic                norm_hit_c;

    // Predecessors and branch metrics of next state ns = cnt
    always_comb begin
        wr_bank_c  = ~sel;
        p0_c       = {cnt[0], 1'b0};
        p1_c       = {cnt[0], 1'b1};
        bm0_c      = bm_reg[branch_cw(G0, G1, {cnt[1], p0_c})];
        bm1_c      = bm_reg[branch_cw(G0, G1, {cnt[1], p1_c})];
        norm_hit_c = NORM_EN && (best_metric >= NORM_THRESH);
    end

    acs u_acs (
        .pm0        (bank[sel][p0_c]),
        .pm1        (bank[sel][p1_c]),
        .bm0        (bm0_c),
        .bm1        (bm1_c),
        .cost_c     (cost_c),
        .decision_c (decision_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; frame_start overrides every handshake
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bm_valid)         state_next = ST_RUN;
            ST_RUN:  if (cnt == 2'd3)      state_next = ST_DONE;
            ST_DONE: if (dec_ready)        state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
        if (frame_start) begin
            state_next = ST_IDLE;
        end
    end

    // Datapath: metric banks, decisions, running min and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank        <= {RESET_METRICS, RESET_METRICS};
            sel         <= 1'b0;
            cnt         <= '0;
            bm_reg      <= '0;
            dec_vec     <= '0;
            best_state  <= '0;
            best_metric <= '0;
            dec_valid   <= 1'b0;
            bm_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            dec_valid <= (state_next == ST_DONE);
            bm_ready  <= (state_next == ST_IDLE);
            busy      <= (state_next != ST_IDLE);
            if (frame_start) begin
                bank[0] <= RESET_METRICS;
                sel     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bm_valid) begin
                            bm_reg <= bm_vec_t'(bm_in);
                            cnt    <= '0;
                        end
                    end
                    ST_RUN: begin
                        bank[wr_bank_c][cnt] <= cost_c;
                        dec_vec[cnt]         <= decision_c;
                        // First state seeds the min; strict '<' keeps lowest index on ties
                        if (cnt == '0 || cost_c < best_metric) begin
                            best_metric <= cost_c;
                            best_state  <= cnt;
                        end
                        cnt <= cnt + 2'd1;
                    end
                    ST_DONE: begin
                        if (dec_ready) begin
                            sel <= wr_bank_c;
                            if (norm_hit_c) begin
                                for (int unsigned s = 0; s < NUM_STATES; s++) begin
                                    if (bank[wr_bank_c][STATE_W'(s)] != INF) begin
                                        bank[wr_bank_c][STATE_W'(s)] <=
                                            bank[wr_bank_c][STATE_W'(s)] - best_metric;
                                    end
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acs_scheduler.sv
// Self-checking bench for acs_scheduler: scoreboard of expected decision
// vectors and metrics from an independent forward-trellis model.
`timescale 1ns/1ps
module tb_acs_scheduler;
    import viterbi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       bm_valid = 1'b0;
    logic       dec_ready = 1'b0;
    logic [7:0] bm_in = '0;
    logic       bm_ready;
    logic       dec_valid;
    logic       busy;
    logic [3:0] dec_vec;
    logic [1:0] best_state;
    logic [3:0] best_metric;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]  dec;
        logic [1:0]  bs;
        logic [3:0]  bm;
        logic [15:0] nm;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_pm;

    always #5 clk = ~clk;

    acs_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .bm_valid    (bm_valid),
        .bm_ready    (bm_ready),
        .bm_in       (bm_in),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_vec     (dec_vec),
        .best_state  (best_state),
        .best_metric (best_metric),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Forward enumeration over (previous state, input bit)
    function automatic exp_t model_step(input logic [15:0] pm, input logic [7:0] bm);
        int   c [4][2];
        int   best;
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            c[s][0] = 15;
            c[s][1] = 15;
        end
        for (int p = 0; p < 4; p++) begin
            for (int u = 0; u < 2; u++) begin
                logic [2:0] r;
                int ns, b, m, cost, idx;
                r    = 3'(u * 4 + p);
                ns   = u * 2 + p / 2;
                idx  = (^(r & 3'b111)) * 2 + (^(r & 3'b101));
                b    = int'(bm[idx*2 +: 2]);
                m    = int'(pm[p*4 +: 4]);
                cost = (m == 15) ? 15 : ((m + b > 15) ? 15 : m + b);
                c[ns][p % 2] = cost;
            end
        end
        e    = '0;
        best = 99;
        for (int ns = 0; ns < 4; ns++) begin
            int m;
            e.dec[ns] = (c[ns][1] < c[ns][0]);
            m = e.dec[ns] ? c[ns][1] : c[ns][0];
            e.nm[ns*4 +: 4] = 4'(m);
            if (m < best) begin
                best = m;
                e.bs = 2'(ns);
            end
        end
        e.bm = 4'(best);
        return e;
    endfunction

    function automatic logic [15:0] commit(input exp_t e);
        logic [15:0] r;
        r = e.nm;
`ifdef METRIC_NORM_EN
        if (e.bm >= 4'd8) begin
            for (int s = 0; s < 4; s++) begin
                if (r[s*4 +: 4] != 4'hF) r[s*4 +: 4] = r[s*4 +: 4] - e.bm;
            end
        end
`endif
        return r;
    endfunction

    task automatic frame_reinit();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        model_pm = 16'hFFF0;
        sb.delete();
    endtask

    task automatic run_symbol(input logic [7:0] bm, input int hold, output logic [3:0] got_best);
        exp_t e;
        int   n;
        n = 0;
        while (!bm_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bm_ready_wait", 32'(bm_ready), 1);
        bm_in    = bm;
        bm_valid = 1'b1;
        sb.push_back(model_step(model_pm, bm));
        @(negedge clk);
        bm_valid = 1'b0;
        check("busy_run", 32'(busy), 1);
        check("bm_ready_run", 32'(bm_ready), 0);
        n = 1;
        while (!dec_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency_edges", 32'(n), 5);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(dec_valid), 1);
            check("hold_vec", 32'(dec_vec), 32'(e.dec));
            check("hold_best_state", 32'(best_state), 32'(e.bs));
            check("hold_best_metric", 32'(best_metric), 32'(e.bm));
            check("hold_bm_ready", 32'(bm_ready), 0);
        end
        check("dec_vec", 32'(dec_vec), 32'(e.dec));
        check("best_state", 32'(best_state), 32'(e.bs));
        check("best_metric", 32'(best_metric), 32'(e.bm));
        got_best  = best_metric;
        model_pm  = commit(e);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        check("dec_valid_clr", 32'(dec_valid), 0);
        check("bm_ready_idle", 32'(bm_ready), 1);
        check("busy_idle", 32'(busy), 0);
        check("bank_cur", 32'(dut.bank[dut.sel]), 32'(model_pm));
    endtask

    initial begin
        logic [3:0] gb;
        int         n;
        int         aa_tab [8];
`ifdef METRIC_NORM_EN
        aa_tab = '{2, 4, 6, 8, 2, 4, 6, 8};
`else
        aa_tab = '{2, 4, 6, 8, 10, 12, 14, 15};
`endif
        model_pm = 16'hFFF0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_bm_ready", 32'(bm_ready), 1);
        check("rst_dec_valid", 32'(dec_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dec_vec", 32'(dec_vec), 0);
        check("rst_best", 32'({best_state, best_metric}), 0);
        check("rst_bank_a", 32'(dut.bank[0]), 32'h0000FFF0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single symbol from the reset metrics
        run_symbol(8'h94, 0, gb);
        check("s2_vec", 32'(dec_vec), 0);
        check("s2_best_state", 32'(best_state), 0);
        check("s2_best_metric", 32'(gb), 0);
        check("s2_new_bank", 32'(dut.bank[1]), 32'h0000F2F0);

        // Back-pressure on the decision output
        run_symbol(8'h94, 10, gb);

        // Metric growth / saturation or normalization
        frame_reinit();
        for (int i = 0; i < 8; i++) begin
            run_symbol(8'hAA, 0, gb);
            check("aa_best_metric", 32'(gb), 32'(aa_tab[i]));
        end

        // frame_start while the third state is being processed
        frame_reinit();
        bm_in    = 8'h94;
        bm_valid = 1'b1;
        @(negedge clk);
        bm_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_cnt", 32'(dut.cnt), 2);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("abort_idle_ready", 32'(bm_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_bank_a", 32'(dut.bank[0]), 32'h0000FFF0);
        check("abort_sel", 32'(dut.sel), 0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dec_valid) n++;
        end
        check("abort_no_valid", 32'(n), 0);
        run_symbol(8'h94, 0, gb);
        check("replay_vec", 32'(dec_vec), 0);
        check("replay_best_state", 32'(best_state), 0);
        check("replay_best_metric", 32'(gb), 0);
        check("replay_bank", 32'(dut.bank[1]), 32'h0000F2F0);

        // Random branch metrics against the model
        for (int i = 0; i < 6; i++) begin
            run_symbol(8'($urandom), i % 3, gb);
        end

        // Asynchronous reset while a decision is pending
        bm_in    = 8'h5A;
        bm_valid = 1'b1;
        @(negedge clk);
        bm_valid = 1'b0;
        n = 0;
        while (!dec_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_valid", 32'(dec_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(dec_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_ready", 32'(bm_ready), 1);
        check("async_rst_bank_a", 32'(dut.bank[0]), 32'h0000FFF0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_pm = 16'hFFF0;
        sb.delete();
        @(negedge clk);
        run_symbol(8'h94, 0, gb);
        check("post_rst_best_metric", 32'(gb), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
